muldiv_unit: RTL and testbench



---
 rtl/muldiv_unit.sv | 167 ++++++++++++++++
 tb/tb_muldiv_unit.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative multiply/divide unit with HI/LO registers (optional MULDIV_EARLY_OUT_EN)
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [3:0]       control,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic             dz,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;
    state_t state, state_nxt;

    logic [CW-1:0]      cnt;
    logic               is_mul;
    logic               neg_res;
    logic               neg_rem;
    logic               div_zero;
    logic [2*WIDTH-1:0] acc;     // mul: running product; div: {remainder, dividend/quotient}
    logic [2*WIDTH-1:0] mcand;   // mul: shifted multiplicand; div: divisor in low word
    logic [WIDTH-1:0]   mplier;  // mul: multiplier bits not yet consumed
    logic [WIDTH-1:0]   raw_a;   // untouched in1, returned in HI on divide by zero

    logic               accept;
    logic               last_iter;
    logic               a_neg;
    logic               b_neg;
    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;
    logic [WIDTH:0]     rem_sh;
    logic               rem_ge;
    logic [WIDTH-1:0]   rem_diff;
    logic [WIDTH-1:0]   rem_next;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix;
    logic [WIDTH-1:0]   rem_fix;
    logic [WIDTH-1:0]   res_hi;
    logic [WIDTH-1:0]   res_lo;

    assign accept = (state == IDLE) && start && (control[3:2] == 2'b11);
    assign busy   = (state != IDLE);

    // Signed ops work on magnitudes; the most negative value maps to 2^(WIDTH-1), which still fits unsigned.
    assign a_neg = control[1] && in1[WIDTH-1];
    assign b_neg = control[1] && in2[WIDTH-1];
    assign a_mag = a_neg ? -in1 : in1;
    assign b_mag = b_neg ? -in2 : in2;

    // Restoring divide step: shift next dividend bit into the remainder and try to subtract the divisor.
    assign rem_sh   = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    assign rem_ge   = (rem_sh >= {1'b0, mcand[WIDTH-1:0]});
    assign rem_diff = rem_sh[WIDTH-1:0] - mcand[WIDTH-1:0];
    assign rem_next = rem_ge ? rem_diff : rem_sh[WIDTH-1:0];

`ifdef MULDIV_EARLY_OUT_EN
    assign last_iter = (cnt == CW'(WIDTH-1)) || (is_mul && (mplier[WIDTH-1:1] == '0));
`else
    assign last_iter = (cnt == CW'(WIDTH-1));
`endif

    // Sign fix-up and divide-by-zero override of the final HI/LO values.
    always_comb begin
        prod_fix = neg_res ? -acc : acc;
        quo_fix  = neg_res ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
        rem_fix  = neg_rem ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
        res_hi   = rem_fix;
        res_lo   = quo_fix;
        if (is_mul) begin
            res_hi = prod_fix[2*WIDTH-1:WIDTH];
            res_lo = prod_fix[WIDTH-1:0];
        end else if (div_zero) begin
            res_hi = raw_a;
            res_lo = '1;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = CALC;
            CALC:    if (last_iter) state_nxt = FIX;
            FIX:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath, HI/LO registers and status flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt      <= '0;
            is_mul   <= 1'b0;
            neg_res  <= 1'b0;
            neg_rem  <= 1'b0;
            div_zero <= 1'b0;
            acc      <= '0;
            mcand    <= '0;
            mplier   <= '0;
            raw_a    <= '0;
            hi       <= '0;
            lo       <= '0;
            done     <= 1'b0;
            dz       <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        cnt      <= '0;
                        is_mul   <= ~control[0];
                        neg_res  <= a_neg ^ b_neg;
                        neg_rem  <= a_neg;
                        div_zero <= control[0] && (in2 == '0);
                        raw_a    <= in1;
                        dz       <= 1'b0;
                        if (!control[0]) begin
                            acc    <= '0;
                            mcand  <= {{WIDTH{1'b0}}, a_mag};
                            mplier <= b_mag;
                        end else begin
                            acc    <= {{WIDTH{1'b0}}, a_mag};
                            mcand  <= {{WIDTH{1'b0}}, b_mag};
                            mplier <= '0;
                        end
                    end else begin
                        if (hi_we) hi <= wdata;
                        if (lo_we) lo <= wdata;
                    end
                end
                CALC: begin
                    cnt <= cnt + 1'b1;
                    if (is_mul) begin
                        if (mplier[0]) acc <= acc + mcand;
                        mcand  <= mcand << 1;
                        mplier <= mplier >> 1;
                    end else begin
                        acc <= {rem_next, acc[WIDTH-2:0], rem_ge};
                    end
                end
                FIX: begin
                    hi   <= res_hi;
                    lo   <= res_lo;
                    dz   <= div_zero;
                    done <= 1'b1;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_muldiv_unit.sv
// tb/tb_muldiv_unit.sv - scoreboard testbench for muldiv_unit
module tb_muldiv_unit;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [3:0]  control = 4'b0;
    logic [31:0] in1 = '0;
    logic [31:0] in2 = '0;
    logic        hi_we = 1'b0;
    logic        lo_we = 1'b0;
    logic [31:0] wdata = '0;
    logic        busy;
    logic        done;
    logic        dz;
    logic [31:0] hi;
    logic [31:0] lo;

    muldiv_unit #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst), .start(start), .control(control),
        .in1(in1), .in2(in2), .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
        .busy(busy), .done(done), .dz(dz), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dz;
        int          lat;
        int          t0;
    } exp_t;

    exp_t        scb[$];
    int          cyc = 0;
    int          n_chk = 0;
    int          n_fail = 0;
    logic [31:0] model_hi = '0;
    logic [31:0] model_lo = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model: plain 64-bit arithmetic on the architectural operand values.
    function automatic exp_t model(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
        exp_t        e;
        longint      sa;
        longint      sbv;
        logic [63:0] p;
        logic [63:0] q;
        logic [63:0] r;
        logic [31:0] bm;
        int          idx;
        e.dz  = 1'b0;
        e.t0  = 0;
        e.lat = 34;
        sa  = c[1] ? {{32{a[31]}}, a} : {32'b0, a};
        sbv = c[1] ? {{32{b[31]}}, b} : {32'b0, b};
        if (!c[0]) begin
            p    = sa * sbv;
            e.hi = p[63:32];
            e.lo = p[31:0];
`ifdef MULDIV_EARLY_OUT_EN
            bm  = (c[1] && b[31]) ? (32'd0 - b) : b;
            idx = 0;
            for (int i = 0; i < 32; i++) if (bm[i]) idx = i;
            e.lat = 3 + idx;
`else
            bm  = b;
            idx = 0;
`endif
        end else if (b == 32'd0) begin
            e.hi = a;
            e.lo = 32'hFFFF_FFFF;
            e.dz = 1'b1;
        end else begin
            q    = sa / sbv;
            r    = sa % sbv;
            e.hi = r[31:0];
            e.lo = q[31:0];
        end
        return e;
    endfunction

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (!rst && done === 1'b1) begin
            chk("done_expected", 64'(scb.size() > 0), 64'd1);
            if (scb.size() > 0) begin
                exp_t e;
                e = scb.pop_front();
                chk("hi", hi, e.hi);
                chk("lo", lo, e.lo);
                chk("dz", dz, e.dz);
                chk("latency", 64'(cyc - e.t0), 64'(e.lat));
            end
        end
    end

    task automatic do_op(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                         input bit hiwe_also, input bit disturb);
        exp_t e;
        int   n;
        int   busy_low;
        int   moved;
        e = model(c, a, b);
        @(negedge clk);
        start   = 1'b1;
        control = c;
        in1     = a;
        in2     = b;
        hi_we   = hiwe_also;
        wdata   = 32'h1234_5678;
        e.t0    = cyc;
        scb.push_back(e);
        @(negedge clk);
        start = 1'b0;
        hi_we = 1'b0;
        n = 0;
        busy_low = 0;
        moved = 0;
        while (done !== 1'b1 && n < 60) begin
            if (busy !== 1'b1) busy_low++;
            if (hi !== model_hi || lo !== model_lo) moved++;
            if (disturb) begin
                if (n == 3) begin hi_we = 1'b1; wdata = 32'hA5A5_A5A5; end
                if (n == 4) hi_we = 1'b0;
                if (n == 6) begin start = 1'b1; control = 4'b1100; in1 = $urandom; in2 = $urandom; end
                if (n == 7) start = 1'b0;
            end
            @(negedge clk);
            n++;
        end
        start = 1'b0;
        hi_we = 1'b0;
        chk("done_within_bound", 64'(n < 60), 64'd1);
        chk("busy_during_op", 64'(busy_low), 64'd0);
        chk("hilo_stable_while_busy", 64'(moved), 64'd0);
        chk("busy_clear_at_done", busy, 64'd0);
        model_hi = e.hi;
        model_lo = e.lo;
    endtask

    function automatic logic [31:0] rnd_op();
        case ($urandom_range(0, 5))
            0:       return 32'd0;
            1:       return 32'h8000_0000;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int ndone;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("reset_hi", hi, 64'd0);
        chk("reset_lo", lo, 64'd0);
        chk("reset_busy", busy, 64'd0);
        chk("reset_done", done, 64'd0);
        chk("reset_dz", dz, 64'd0);

        do_op(4'b1100, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0);
        do_op(4'b1110, 32'hFFFF_FFFD, 32'd5, 1'b0, 1'b0);
        do_op(4'b1111, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0);
        do_op(4'b1111, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0);
        do_op(4'b1101, 32'd100, 32'd0, 1'b0, 1'b0);
        do_op(4'b1101, 32'd100, 32'd7, 1'b0, 1'b0);
        do_op(4'b1100, 32'd3, 32'd5, 1'b1, 1'b1);

        // Start with a non-muldiv control code is not accepted, so the register writes land.
        @(negedge clk);
        start = 1'b1; control = 4'b0101; hi_we = 1'b1; wdata = 32'hA5A5_A5A5;
        @(negedge clk);
        start = 1'b0; hi_we = 1'b0;
        chk("ignored_start_busy", busy, 64'd0);
        chk("mthi_idle", hi, 64'hA5A5_A5A5);
        lo_we = 1'b1; wdata = 32'h5A5A_5A5A;
        @(negedge clk);
        lo_we = 1'b0;
        chk("mtlo_idle", lo, 64'h5A5A_5A5A);
        chk("mtlo_keeps_hi", hi, 64'hA5A5_A5A5);
        model_hi = 32'hA5A5_A5A5;
        model_lo = 32'h5A5A_5A5A;

        // Reset in the middle of a divide aborts it without a done pulse.
        @(negedge clk);
        start = 1'b1; control = 4'b1101; in1 = 32'd1000; in2 = 32'd3;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_hi", hi, 64'd0);
        chk("abort_lo", lo, 64'd0);
        chk("abort_busy", busy, 64'd0);
        model_hi = '0;
        model_lo = '0;
        ndone = 0;
        repeat (40) begin
            @(negedge clk);
            if (done === 1'b1) ndone++;
        end
        chk("no_done_after_abort", 64'(ndone), 64'd0);
        do_op(4'b1101, 32'd1000, 32'd3, 1'b0, 1'b0);

        for (int i = 0; i < 40; i++) begin
            do_op({2'b11, 2'($urandom_range(0, 3))}, rnd_op(), rnd_op(),
                  1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0));
        end

        repeat (3) @(negedge clk);
        chk("scoreboard_drained", 64'(scb.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation exceeded its time limit");
        $fatal(1);
    end
endmodule
